// File: rtl/gen_step_scheduler.sv
// Generation pacing: programmable period, run/pause/single-step, req/ack to engine.
// Optional GEN_LIMIT_EN adds gen_limit/halted to stop after a set generation count.
module gen_step_scheduler #(
  parameter int unsigned     N          = 22,
  parameter logic [N-1:0]    DEF_PERIOD = 22'd4194303,
  parameter int unsigned     GW         = 16
) (
  input  logic          clk_in,
  input  logic          rstn,
  input  logic          run,
  input  logic          step,
  input  logic          cfg_we,
  input  logic [N-1:0]  cfg_period,
  output logic          step_req,
  input  logic          step_ack,
  output logic          busy,
`ifdef GEN_LIMIT_EN
  input  logic [GW-1:0] gen_limit,
  output logic          halted,
`endif
  output logic [GW-1:0] gen_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

  localparam logic [N-1:0]  ONE_N  = N'(1);
  localparam logic [GW-1:0] ONE_GW = GW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  period_q, period_d;
  logic [GW-1:0] gen_q, gen_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          run_ok;

`ifdef GEN_LIMIT_EN
  // A halted scheduler ignores run until run is seen low once.
  assign run_ok = run & ~halted_q;
`else
  assign run_ok = run;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gen_d    = gen_q;
    halted_d = halted_q;
    period_d = period_q;
`ifdef GEN_LIMIT_EN
    if (!run) halted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (run_ok) begin
          state_d = COUNT;
          cnt_d   = '0;
        end else if (step) begin
          state_d = REQ;
        end
      end
      COUNT: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_q - ONE_N) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_N;
        end
      end
      REQ: begin
        // Counter is frozen here, so the period runs ack-to-request.
        if (step_ack) begin
          gen_d   = gen_q + ONE_GW;
          cnt_d   = '0;
          state_d = run_ok ? COUNT : IDLE;
`ifdef GEN_LIMIT_EN
          if ((gen_limit != '0) && (gen_d == gen_limit)) begin
            state_d  = IDLE;
            halted_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (cfg_we) begin
      cnt_d    = '0;
      period_d = (cfg_period == '0) ? ONE_N : cfg_period;
    end
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= DEF_PERIOD;
      gen_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      gen_q    <= gen_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign step_req  = req_q;
  assign busy      = busy_q;
  assign gen_count = gen_q;
`ifdef GEN_LIMIT_EN
  assign halted    = halted_q;
`else
  logic unused_halted;
  assign unused_halted = halted_q ^ halted_d;
`endif

endmodule

// File: tb/tb_gen_step_scheduler.sv
// Self-checking bench for gen_step_scheduler: timing model, random periods/ack delays,
// counter wrap on a narrow instance, reset mid-handshake, optional generation limit.
module tb_gen_step_scheduler;
  localparam int N  = 22;
  localparam int GW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, run, step, cfg_we, step_ack;
  logic [N-1:0]  cfg_period;
  logic          step_req, busy;
  logic [GW-1:0] gen_count;

  logic          w_run, w_step, w_cfg_we, w_ack, w_req, w_busy;
  logic [7:0]    w_cfg_period;
  logic [3:0]    w_gen;

`ifdef GEN_LIMIT_EN
  logic [GW-1:0] gen_limit;
  logic          halted;
  logic [3:0]    w_limit;
  logic          w_halted;
`endif

  int checks = 0;
  int fails  = 0;
  int exp_gen = 0;

  gen_step_scheduler dut (
    .clk_in(clk), .rstn(rstn), .run(run), .step(step),
    .cfg_we(cfg_we), .cfg_period(cfg_period),
    .step_req(step_req), .step_ack(step_ack), .busy(busy),
`ifdef GEN_LIMIT_EN
    .gen_limit(gen_limit), .halted(halted),
`endif
    .gen_count(gen_count)
  );

  gen_step_scheduler #(.N(8), .DEF_PERIOD(8'd1), .GW(4)) u_wrap (
    .clk_in(clk), .rstn(rstn), .run(w_run), .step(w_step),
    .cfg_we(w_cfg_we), .cfg_period(w_cfg_period),
    .step_req(w_req), .step_ack(w_ack), .busy(w_busy),
`ifdef GEN_LIMIT_EN
    .gen_limit(w_limit), .halted(w_halted),
`endif
    .gen_count(w_gen)
  );

  task automatic wait_req(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_req && n < max);
  endtask

  // Engine model: called with step_req just seen high; holds it d cycles.
  task automatic serve(input int d);
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      checks++;
      if (step_req !== 1'b1) begin
        fails++;
        $display("FAIL serve_hold: step_req=%b want 1 (cycle %0d of %0d)", step_req, i + 1, d);
      end
    end
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    exp_gen = (exp_gen + 1) % (1 << GW);
    checks++;
    if (step_req !== 1'b0) begin
      fails++;
      $display("FAIL serve_drop: step_req=%b want 0", step_req);
    end
    checks++;
    if (gen_count !== GW'(exp_gen)) begin
      fails++;
      $display("FAIL gen_count: got %0d want %0d", gen_count, exp_gen);
    end
  endtask

  task automatic cfg_write(input logic [N-1:0] p);
    cfg_we = 1'b1;
    cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (step_req !== 1'b0 || busy !== 1'b0 || gen_count !== '0) begin
        fails++;
        $display("FAIL reset_state: req=%b busy=%b gen=%0d want 0/0/0", step_req, busy, gen_count);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_period;
    int n;
    cfg_write(22'd4);
    run = 1'b1;
    wait_req(30, n);
    checks++;
    if (step_req !== 1'b1 || n != 5) begin
      fails++;
      $display("FAIL first_req: req=%b after %0d edges want 1 after 5", step_req, n);
    end
    for (int g = 0; g < 3; g++) begin
      serve(2);
      checks++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL count_busy: busy=%b want 1", busy);
      end
      if (g < 2) begin
        wait_req(30, n);
        checks++;
        if (step_req !== 1'b1 || n != 4) begin
          fails++;
          $display("FAIL ack_to_req: req=%b after %0d want 1 after 4", step_req, n);
        end
      end
    end
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || step_req !== 1'b0 || gen_count !== 16'd3) begin
      fails++;
      $display("FAIL pause: busy=%b req=%b gen=%0d want 0/0/3", busy, step_req, gen_count);
    end
  endtask

  task automatic test_step;
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    checks++;
    if (gen_count !== GW'(exp_gen) || step_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_ack: gen=%0d req=%b want %0d/0", gen_count, step_req, exp_gen);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (step_req !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL step_req: req=%b busy=%b want 1/1", step_req, busy);
    end
    serve(7);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL step_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_run_step;
    int n;
    run = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (step_req !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL run_wins: req=%b busy=%b want 0/1", step_req, busy);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (step_req !== 1'b0) begin
      fails++;
      $display("FAIL step_in_count: req=%b want 0", step_req);
    end
    wait_req(30, n);
    checks++;
    if (step_req !== 1'b1 || n != 3) begin
      fails++;
      $display("FAIL count_req: req=%b after %0d want 1 after 3", step_req, n);
    end
    run = 1'b0;
    serve(3);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || step_req !== 1'b0) begin
      fails++;
      $display("FAIL run_fall_req: busy=%b req=%b want 0/0", busy, step_req);
    end
  endtask

  task automatic test_random;
    int n, p, eff, d;
    for (int k = 0; k < 6; k++) begin
      p = (k == 0) ? 0 : int'($urandom_range(1, 6));
      eff = (p == 0) ? 1 : p;
      cfg_write(N'(p));
      run = 1'b1;
      wait_req(40, n);
      checks++;
      if (step_req !== 1'b1 || n != eff + 1) begin
        fails++;
        $display("FAIL rand_first p=%0d: req=%b after %0d want after %0d", p, step_req, n, eff + 1);
      end
      for (int g = 0; g < 3; g++) begin
        d = int'($urandom_range(1, 4));
        if (g == 2) run = 1'b0;
        serve(d);
        if (g < 2) begin
          wait_req(40, n);
          checks++;
          if (step_req !== 1'b1 || n != eff) begin
            fails++;
            $display("FAIL rand_period p=%0d: req=%b after %0d want after %0d", p, step_req, n, eff);
          end
        end
      end
      checks++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rand_idle: busy=%b want 0", busy);
      end
    end
  endtask

  task automatic test_wrap;
    int acks = 0;
    w_run = 1'b1;
    for (int i = 0; i < 400 && acks < 17; i++) begin
      @(negedge clk);
      if (w_ack) begin
        acks++;
        w_ack = 1'b0;
        checks++;
        if (w_gen !== 4'(acks % 16)) begin
          fails++;
          $display("FAIL wrap_gen: got %0d want %0d", w_gen, acks % 16);
        end
      end else if (w_req) begin
        w_ack = 1'b1;
      end
    end
    w_run = 1'b0;
    checks++;
    if (acks != 17) begin
      fails++;
      $display("FAIL wrap_timeout: acks=%0d want 17", acks);
    end
  endtask

`ifdef GEN_LIMIT_EN
  task automatic test_limit;
    int n;
    bit extra = 0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_gen = 0;
    cfg_write(22'd4);
    gen_limit = 16'd2;
    run = 1'b1;
    for (int g = 0; g < 2; g++) begin
      wait_req(30, n);
      serve(2);
    end
    checks++;
    if (busy !== 1'b0 || halted !== 1'b1) begin
      fails++;
      $display("FAIL limit_halt: busy=%b halted=%b want 0/1", busy, halted);
    end
    repeat (10) begin
      @(negedge clk);
      if (step_req || busy) extra = 1;
    end
    checks++;
    if (extra) begin
      fails++;
      $display("FAIL limit_hold: request while halted, want none");
    end
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_clear: halted=%b want 0", halted);
    end
    gen_limit = '0;
  endtask
`endif

  task automatic test_reset_mid;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (step_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_req: req=%b want 1", step_req);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (step_req !== 1'b0 || busy !== 1'b0 || gen_count !== '0) begin
      fails++;
      $display("FAIL mid_reset: req=%b busy=%b gen=%0d want 0/0/0", step_req, busy, gen_count);
    end
    rstn = 1'b1;
    exp_gen = 0;
  endtask

  initial begin
    rstn = 1'b0;
    run = 1'b0;
    step = 1'b0;
    cfg_we = 1'b0;
    cfg_period = '0;
    step_ack = 1'b0;
    w_run = 1'b0;
    w_step = 1'b0;
    w_cfg_we = 1'b0;
    w_cfg_period = '0;
    w_ack = 1'b0;
`ifdef GEN_LIMIT_EN
    gen_limit = '0;
    w_limit = '0;
`endif
    test_reset();
    test_period();
    test_step();
    test_run_step();
    test_random();
    test_wrap();
`ifdef GEN_LIMIT_EN
    test_limit();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
